exec_mc: RTL and testbench
==========================

Name: exec_mc

Overview:
Parametrised successor of the single-cycle execute stage, sitting between decode/operand-fetch and memory/writeback.
- Adds an opcode-selected integer ALU (add/sub/logic/shift/pass).
- Adds an iterative shift-add multiplier that stalls the upstream stage.
- Adds PC-relative branch-on-zero next to absolute jumps.
- Adds a valid/ready handshake so downstream sees qualified results.

Parameters:
IALU_WORD_WIDTH, 16, ALU/operand/result width (power of two, >=8)
PC_WIDTH, 12, program-counter width (<= IALU_WORD_WIDTH)
PMEM_ADDR_WIDTH, 12, branch/jump target width
DMEM_ADDR_WIDTH, 12, data-memory address width (<= IALU_WORD_WIDTH)
REG_IDX_WIDTH, 4, register index width
OP_WIDTH, 3, ALU opcode width
PC_INCREMENT, 2, link-address increment

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream holds a valid instruction
in_op  in  OP_WIDTH  ALU opcode
in_act_incr_pc_is_res  in  1  result = pc + PC_INCREMENT
in_act_jump  in  1  jump to ALU result
in_act_branch_zero  in  1  branch if src1 == 0
in_act_load_dmem  in  1  load request
in_act_store_dmem  in  1  store request
in_act_write_res_to_reg  in  1  writeback request
in_pc  in  PC_WIDTH  instruction PC
in_res_reg_idx  in  REG_IDX_WIDTH  destination register
in_src1  in  IALU_WORD_WIDTH  operand 1
in_src2  in  IALU_WORD_WIDTH  operand 2
out_ready  out  1  stage accepts an instruction this cycle
out_valid  out  1  result and side-band signals valid
out_res  out  IALU_WORD_WIDTH  result
out_res_reg_idx  out  REG_IDX_WIDTH  destination register
out_act_load_dmem / out_act_store_dmem / out_act_write_res_to_reg  out  1 each  forwarded actions, gated by out_valid
out_dmem_rd_addr  out  DMEM_ADDR_WIDTH  src1 low bits when load, else 0
out_dmem_wr_addr  out  DMEM_ADDR_WIDTH  src1 low bits when store, else 0
out_dmem_wr_word  out  IALU_WORD_WIDTH  src2 when store, else 0
out_flush / out_set_pc  out  1 each  taken jump/branch
out_new_pc  out  PMEM_ADDR_WIDTH  target, 0 when not taken

Behaviour:
- Reset:
  - Async on reset low: state IDLE; all sampled regs, counter and accumulator cleared.
  - All outputs 0 except out_ready=1.
  - Reset mid-multiply abandons the operation; no out_valid is produced for it.
- Capture: on a rising edge with in_valid && out_ready, all inputs are registered. Otherwise the sampled regs hold, and out_valid=0 on the next cycle (bubble).
- Opcodes:
  - 0 ADD, 1 SUB (src1-src2), 2 AND, 3 OR, 4 XOR, 5 PASS_SRC2.
  - 6 SHL: src1 << src2[log2(W)-1:0].
  - 7 MUL: low W bits of the product.
  - All arithmetic is modulo 2^W, with no flags.
- Single-cycle ops:
  - out_valid=1 in the cycle after capture.
  - Outputs are combinational from the sampled regs (latency 1).
- MUL FSM (IDLE, MUL, DONE):
  - IDLE->MUL on capturing op 7. Accumulator cleared; counter = W-1.
  - In MUL: if the multiplier LSB is set, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter.
  - MUL->DONE when counter == 0, after exactly W iterations.
  - DONE: out_valid=1 with out_res = accumulator. DONE->IDLE unless a new op 7 is captured in the same cycle, which goes to MUL.
  - out_ready=0 only in MUL. Latency is W+1 cycles from capture.
- Result mux: if act_incr_pc_is_res, out_res = {zeros, (pc + PC_INCREMENT) mod 2^PC_WIDTH}; otherwise the ALU/MUL result.
- Control transfer (only while out_valid):
  - jump: target = out_res[PMEM_ADDR_WIDTH-1:0].
  - branch_zero taken when src1==0: target = (pc + src2) truncated to PMEM_ADDR_WIDTH.
  - When taken, out_flush = out_set_pc = 1 for exactly one cycle.
  - If jump and branch are both set, jump wins.
- Side-band: act flags and reg idx come from the sampled regs ANDed with out_valid. For MUL they are held until DONE.

Optional Feature:
EXEC_MC_MUL_EN
- Defined: iterative multiplier and FSM as above.
- Undefined: no FSM or accumulator; out_ready tied 1; op 7 completes in one cycle with out_res=0, and all other behaviour is unchanged.

Decomposition:
- Package exec_mc_pkg:
  - Opcode localparams OP_ADD..OP_MUL.
  - FSM state encoding (IDLE/MUL/DONE).
  - Shift-amount width function clog2(IALU_WORD_WIDTH).
- Sub-module exec_mul_iter:
  - Holds the shift-add datapath, counter and done pulse.
  - Instantiated only under EXEC_MC_MUL_EN.

Test Plan:
- ADD 0x1234+0x0F0F -> out_res=0x2143, out_valid=1 one cycle after capture; SUB 0x0005-0x0007 -> 0xFFFE.
- MUL 0x0123*0x0010 -> out_ready=0 for 16 cycles, out_valid on cycle 17 with 0x1230; back-to-back MUL captured in DONE -> second result 17 cycles later.
- Branch_zero src1=0, pc=0x100, src2=0x0010 -> out_flush=out_set_pc=1 for one cycle, out_new_pc=0x110; src1=1 -> no flush, out_new_pc=0.
- incr_pc_is_res with pc=0xFFE -> out_res=0x0000 (wrap, upper bits 0); jump with ADD 0x0040+0x0004 -> out_new_pc=0x044.
- Store src1=0x0ABC, src2=0x5A5A -> out_dmem_wr_addr=0xABC, out_dmem_wr_word=0x5A5A, out_act_store_dmem=1; load -> out_dmem_rd_addr=src1 low bits.
- reset low at iteration 8 of a MUL -> all outputs 0, out_ready=1; no later out_valid for that MUL.

Source files
------------

// File: rtl/exec_mc_pkg.sv
// Shared opcodes, FSM state type and width helper for the exec_mc execute stage.
package exec_mc_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_PASS = 5;
    localparam int OP_SHL  = 6;
    localparam int OP_MUL  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int unsigned value);
        int          r;
        int unsigned v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/exec_mc_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, W iterations.
module exec_mul_iter
    import exec_mc_pkg::*;
#(
    parameter int IALU_WORD_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic                       i_run,
    input  logic [IALU_WORD_WIDTH-1:0] i_a,
    input  logic [IALU_WORD_WIDTH-1:0] i_b,
    output logic                       o_last,
    output logic [IALU_WORD_WIDTH-1:0] o_product
);

    localparam int W  = IALU_WORD_WIDTH;
    localparam int CW = clog2(W);

    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_mplier;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CW'(W - 1);
        end else if (i_run) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    assign o_last    = i_run && (r_cnt == '0);
    assign o_product = r_acc;

endmodule

// File: rtl/exec_mc.sv
// Multi-cycle execute stage: ALU, optional iterative MUL (EXEC_MC_MUL_EN),
// branch/jump resolution and valid/ready handshake toward memory/writeback.
module exec_mc
    import exec_mc_pkg::*;
#(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int OP_WIDTH        = 3,
    parameter int PC_INCREMENT    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [OP_WIDTH-1:0]        in_op,
    input  logic                       in_act_incr_pc_is_res,
    input  logic                       in_act_jump,
    input  logic                       in_act_branch_zero,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [IALU_WORD_WIDTH-1:0] in_src1,
    input  logic [IALU_WORD_WIDTH-1:0] in_src2,
    output logic                       out_ready,
    output logic                       out_valid,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic                       out_act_load_dmem,
    output logic                       out_act_store_dmem,
    output logic                       out_act_write_res_to_reg,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
    output logic [IALU_WORD_WIDTH-1:0] out_dmem_wr_word,
    output logic                       out_flush,
    output logic                       out_set_pc,
    output logic [PMEM_ADDR_WIDTH-1:0] out_new_pc
);

    localparam int W   = IALU_WORD_WIDTH;
    localparam int SHW = clog2(W);

    logic                     r_cap;
    logic [OP_WIDTH-1:0]      r_op;
    logic                     r_incr, r_jump, r_bz, r_ld, r_st, r_wr;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [REG_IDX_WIDTH-1:0] r_idx;
    logic [W-1:0]             r_src1, r_src2;

    logic                       w_capture, w_ready, w_valid;
    logic [W-1:0]               w_alu, w_res, w_mul_res;
    logic [PC_WIDTH-1:0]        w_pc_inc;
    logic [PMEM_ADDR_WIDTH-1:0] w_br_target;
    logic                       w_jump_tk, w_br_tk;

    assign w_capture = in_valid && w_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cap  <= 1'b0;
            r_op   <= '0;
            r_incr <= 1'b0;
            r_jump <= 1'b0;
            r_bz   <= 1'b0;
            r_ld   <= 1'b0;
            r_st   <= 1'b0;
            r_wr   <= 1'b0;
            r_pc   <= '0;
            r_idx  <= '0;
            r_src1 <= '0;
            r_src2 <= '0;
        end else begin
            r_cap <= w_capture;
            if (w_capture) begin
                r_op   <= in_op;
                r_incr <= in_act_incr_pc_is_res;
                r_jump <= in_act_jump;
                r_bz   <= in_act_branch_zero;
                r_ld   <= in_act_load_dmem;
                r_st   <= in_act_store_dmem;
                r_wr   <= in_act_write_res_to_reg;
                r_pc   <= in_pc;
                r_idx  <= in_res_reg_idx;
                r_src1 <= in_src1;
                r_src2 <= in_src2;
            end
        end
    end

`ifdef EXEC_MC_MUL_EN
    state_t       r_state, w_state_nxt;
    logic         w_mul_start, w_mul_run, w_mul_last;
    logic [W-1:0] w_product;

    assign w_mul_start = w_capture && (in_op == OP_WIDTH'(OP_MUL));
    assign w_mul_run   = (r_state == ST_MUL);
    assign w_mul_res   = w_product;

    exec_mul_iter #(
        .IALU_WORD_WIDTH(IALU_WORD_WIDTH)
    ) u_mul (
        .clk      (clock),
        .rst_n    (reset),
        .i_start  (w_mul_start),
        .i_run    (w_mul_run),
        .i_a      (in_src1),
        .i_b      (in_src2),
        .o_last   (w_mul_last),
        .o_product(w_product)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sampled regs cannot change during MUL (ready is low), so DONE reuses them.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b1;
        w_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_valid = r_cap;
                if (w_mul_start) w_state_nxt = ST_MUL;
            end
            ST_MUL: begin
                w_ready = 1'b0;
                if (w_mul_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_valid     = 1'b1;
                w_state_nxt = w_mul_start ? ST_MUL : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
`else
    assign w_ready   = 1'b1;
    assign w_valid   = r_cap;
    assign w_mul_res = '0;
`endif

    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_WIDTH'(OP_ADD):  w_alu = r_src1 + r_src2;
            OP_WIDTH'(OP_SUB):  w_alu = r_src1 - r_src2;
            OP_WIDTH'(OP_AND):  w_alu = r_src1 & r_src2;
            OP_WIDTH'(OP_OR):   w_alu = r_src1 | r_src2;
            OP_WIDTH'(OP_XOR):  w_alu = r_src1 ^ r_src2;
            OP_WIDTH'(OP_PASS): w_alu = r_src2;
            OP_WIDTH'(OP_SHL):  w_alu = r_src1 << r_src2[SHW-1:0];
            default:            w_alu = w_mul_res;
        endcase
    end

    assign w_pc_inc    = r_pc + PC_WIDTH'(PC_INCREMENT);
    assign w_res       = r_incr ? W'(w_pc_inc) : w_alu;
    assign w_br_target = PMEM_ADDR_WIDTH'(r_pc) + r_src2[PMEM_ADDR_WIDTH-1:0];
    assign w_jump_tk   = w_valid && r_jump;
    assign w_br_tk     = w_valid && r_bz && (r_src1 == '0);

    assign out_ready                = w_ready;
    assign out_valid                = w_valid;
    assign out_res                  = w_valid ? w_res : '0;
    assign out_res_reg_idx          = w_valid ? r_idx : '0;
    assign out_act_load_dmem        = w_valid && r_ld;
    assign out_act_store_dmem       = w_valid && r_st;
    assign out_act_write_res_to_reg = w_valid && r_wr;
    assign out_dmem_rd_addr         = (w_valid && r_ld) ? r_src1[DMEM_ADDR_WIDTH-1:0] : '0;
    assign out_dmem_wr_addr         = (w_valid && r_st) ? r_src1[DMEM_ADDR_WIDTH-1:0] : '0;
    assign out_dmem_wr_word         = (w_valid && r_st) ? r_src2 : '0;
    assign out_flush                = w_jump_tk || w_br_tk;
    assign out_set_pc               = w_jump_tk || w_br_tk;
    assign out_new_pc               = w_jump_tk ? w_res[PMEM_ADDR_WIDTH-1:0] :
                                      w_br_tk   ? w_br_target : '0;

endmodule

// File: tb/tb_exec_mc.sv
// Randomized bench for exec_mc against a transaction-level model; honours EXEC_MC_MUL_EN.
module tb_exec_mc;

    localparam int W = 16;
`ifdef EXEC_MC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_op = '0;
    logic        in_act_incr_pc_is_res = 1'b0, in_act_jump = 1'b0, in_act_branch_zero = 1'b0;
    logic        in_act_load_dmem = 1'b0, in_act_store_dmem = 1'b0, in_act_write_res_to_reg = 1'b0;
    logic [11:0] in_pc = '0;
    logic [3:0]  in_res_reg_idx = '0;
    logic [15:0] in_src1 = '0, in_src2 = '0;

    logic        out_ready, out_valid;
    logic [15:0] out_res;
    logic [3:0]  out_res_reg_idx;
    logic        out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg;
    logic [11:0] out_dmem_rd_addr, out_dmem_wr_addr;
    logic [15:0] out_dmem_wr_word;
    logic        out_flush, out_set_pc;
    logic [11:0] out_new_pc;

    always #5 clock = ~clock;

    exec_mc #(
        .IALU_WORD_WIDTH(16),
        .PC_WIDTH(12),
        .PMEM_ADDR_WIDTH(12),
        .DMEM_ADDR_WIDTH(12),
        .REG_IDX_WIDTH(4),
        .OP_WIDTH(3),
        .PC_INCREMENT(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_op(in_op),
        .in_act_incr_pc_is_res(in_act_incr_pc_is_res),
        .in_act_jump(in_act_jump),
        .in_act_branch_zero(in_act_branch_zero),
        .in_act_load_dmem(in_act_load_dmem),
        .in_act_store_dmem(in_act_store_dmem),
        .in_act_write_res_to_reg(in_act_write_res_to_reg),
        .in_pc(in_pc),
        .in_res_reg_idx(in_res_reg_idx),
        .in_src1(in_src1),
        .in_src2(in_src2),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_res(out_res),
        .out_res_reg_idx(out_res_reg_idx),
        .out_act_load_dmem(out_act_load_dmem),
        .out_act_store_dmem(out_act_store_dmem),
        .out_act_write_res_to_reg(out_act_write_res_to_reg),
        .out_dmem_rd_addr(out_dmem_rd_addr),
        .out_dmem_wr_addr(out_dmem_wr_addr),
        .out_dmem_wr_word(out_dmem_wr_word),
        .out_flush(out_flush),
        .out_set_pc(out_set_pc),
        .out_new_pc(out_new_pc)
    );

    typedef struct {
        bit        v;
        bit [2:0]  op;
        bit        incr, jmp, bz, ld, st, wr;
        bit [11:0] pc;
        bit [3:0]  idx;
        bit [15:0] a, b;
    } ins_t;

    typedef struct {
        int        due;
        bit        valid;
        bit [15:0] res;
        bit [3:0]  idx;
        bit        ld, st, wr, fl;
        bit [11:0] rd, wa, npc;
        bit [15:0] ww;
    } rec_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mul_j = -1000;
    bit   run_en = 1'b0;
    rec_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The stage is busy for W cycles after an accepted multiply.
    function automatic bit model_ready(input int k);
        if (!MUL_EN) return 1'b1;
        return !(k >= mul_j + 1 && k <= mul_j + W);
    endfunction

    function automatic rec_t model(input ins_t i);
        rec_t        r;
        int unsigned a, b, v;
        bit          taken;
        a = i.a;
        b = i.b;
        case (i.op)
            3'd0:    v = a + b;
            3'd1:    v = a - b;
            3'd2:    v = a & b;
            3'd3:    v = a | b;
            3'd4:    v = a ^ b;
            3'd5:    v = b;
            3'd6:    v = a << (b % 16);
            default: v = MUL_EN ? a * b : 0;
        endcase
        v = v % 65536;
        if (i.incr) v = (32'(i.pc) + 2) % 4096;
        taken   = i.jmp || (i.bz && a == 0);
        r       = '{default: 0};
        r.valid = 1'b1;
        r.res   = 16'(v);
        r.idx   = i.idx;
        r.ld    = i.ld;
        r.st    = i.st;
        r.wr    = i.wr;
        r.rd    = i.ld ? 12'(a % 4096) : 12'd0;
        r.wa    = i.st ? 12'(a % 4096) : 12'd0;
        r.ww    = i.st ? 16'(b) : 16'd0;
        r.fl    = taken;
        r.npc   = i.jmp ? 12'(v % 4096) : (taken ? 12'((32'(i.pc) + b) % 4096) : 12'd0);
        return r;
    endfunction

    rec_t e;
    always @(negedge clock) begin
        if (run_en) begin
            e = '{default: 0};
            if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
            chk("valid", out_valid, e.valid);
            if (e.valid) chk("res", out_res, e.res);
            chk("ready", out_ready, model_ready(cyc));
            chk("idx", out_res_reg_idx, e.idx);
            chk("load", out_act_load_dmem, e.ld);
            chk("store", out_act_store_dmem, e.st);
            chk("write", out_act_write_res_to_reg, e.wr);
            chk("rd_addr", out_dmem_rd_addr, e.rd);
            chk("wr_addr", out_dmem_wr_addr, e.wa);
            chk("wr_word", out_dmem_wr_word, e.ww);
            chk("flush", out_flush, e.fl);
            chk("set_pc", out_set_pc, e.fl);
            chk("new_pc", out_new_pc, e.npc);
        end
    end

    task automatic drive(input ins_t i);
        rec_t r;
        @(negedge clock);
        #1;
        in_valid                = i.v;
        in_op                   = i.op;
        in_act_incr_pc_is_res   = i.incr;
        in_act_jump             = i.jmp;
        in_act_branch_zero      = i.bz;
        in_act_load_dmem        = i.ld;
        in_act_store_dmem       = i.st;
        in_act_write_res_to_reg = i.wr;
        in_pc                   = i.pc;
        in_res_reg_idx          = i.idx;
        in_src1                 = i.a;
        in_src2                 = i.b;
        if (run_en) begin
            if (i.v && model_ready(cyc)) begin
                r = model(i);
                if (MUL_EN && i.op == 3'd7) begin
                    r.due = cyc + 1 + W;
                    mul_j = cyc;
                end else begin
                    r.due = cyc + 1;
                end
                q.push_back(r);
            end
            cyc++;
        end
    endtask

    function automatic ins_t mk(input bit [2:0] op, input bit [15:0] a, input bit [15:0] b);
        ins_t i;
        i    = '{default: 0};
        i.v  = 1'b1;
        i.op = op;
        i.a  = a;
        i.b  = b;
        return i;
    endfunction

    task automatic idle();
        ins_t n;
        n = '{default: 0};
        drive(n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_ready"}, out_ready, 1);
        chk({tag, "_res"}, out_res, 0);
        chk({tag, "_idx"}, out_res_reg_idx, 0);
        chk({tag, "_acts"}, {out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg}, 0);
        chk({tag, "_dmem"}, {out_dmem_rd_addr, out_dmem_wr_addr}, 0);
        chk({tag, "_word"}, out_dmem_wr_word, 0);
        chk({tag, "_pc"}, {out_flush, out_set_pc, out_new_pc}, 0);
    endtask

    initial begin
        ins_t x;
        #12;
        chk_all_zero("reset");
        @(negedge clock);
        #1;
        reset  = 1'b1;
        run_en = 1'b1;

        x = mk(0, 16'h1234, 16'h0F0F); drive(x);
        x = mk(1, 16'h0005, 16'h0007); drive(x);
        chk("add_lit", out_res, 16'h2143);
        chk("add_valid", out_valid, 1);
        idle();
        chk("sub_lit", out_res, 16'hFFFE);
        idle();
        chk("bubble_valid", out_valid, 0);

        x = mk(7, 16'h0123, 16'h0010); drive(x);
`ifdef EXEC_MC_MUL_EN
        for (int i = 0; i < 16; i++) begin
            idle();
            chk("mul_stall_ready", out_ready, 0);
        end
        x = mk(7, 16'h0003, 16'h0005); drive(x);
        chk("mul_valid", out_valid, 1);
        chk("mul_lit", out_res, 16'h1230);
        for (int i = 0; i < 16; i++) begin
            idle();
            chk("mul2_stall_ready", out_ready, 0);
        end
        idle();
        chk("mul2_valid", out_valid, 1);
        chk("mul2_lit", out_res, 16'h000F);
`else
        idle();
        chk("mul_off_valid", out_valid, 1);
        chk("mul_off_res", out_res, 0);
        chk("mul_off_ready", out_ready, 1);
`endif

        x = mk(0, 16'h0000, 16'h0010); x.bz = 1; x.pc = 12'h100; drive(x);
        x = mk(0, 16'h0001, 16'h0010); x.bz = 1; x.pc = 12'h100; drive(x);
        chk("bz_flush", out_flush, 1);
        chk("bz_set_pc", out_set_pc, 1);
        chk("bz_target", out_new_pc, 12'h110);
        idle();
        chk("bz_nt_flush", out_flush, 0);
        chk("bz_nt_target", out_new_pc, 0);

        x = mk(0, 16'h0000, 16'h0000); x.incr = 1; x.pc = 12'hFFE; drive(x);
        x = mk(0, 16'h0040, 16'h0004); x.jmp = 1; drive(x);
        chk("incr_wrap", out_res, 16'h0000);
        chk("incr_valid", out_valid, 1);
        idle();
        chk("jump_target", out_new_pc, 12'h044);
        chk("jump_flush", out_flush, 1);

        x = mk(5, 16'h0ABC, 16'h5A5A); x.st = 1; drive(x);
        x = mk(0, 16'h0123, 16'h0000); x.ld = 1; x.wr = 1; x.idx = 4'd9; drive(x);
        chk("st_addr", out_dmem_wr_addr, 12'hABC);
        chk("st_word", out_dmem_wr_word, 16'h5A5A);
        chk("st_act", out_act_store_dmem, 1);
        idle();
        chk("ld_addr", out_dmem_rd_addr, 12'h123);
        chk("ld_act", out_act_load_dmem, 1);
        chk("ld_idx", out_res_reg_idx, 4'd9);

        // Reset lands partway through a multiply.
        x = mk(7, 16'h1111, 16'h2222); drive(x);
        for (int i = 0; i < 8; i++) idle();
        run_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk_all_zero("midmul_reset");
        @(negedge clock);
        #1;
        q.delete();
        mul_j  = -1000;
        reset  = 1'b1;
        run_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            idle();
            chk("no_valid_after_reset", out_valid, 0);
        end

        for (int n = 0; n < 600; n++) begin
            x     = '{default: 0};
            x.v   = ($urandom_range(0, 9) < 7);
            x.op  = 3'($urandom_range(0, 7));
            x.a   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            x.b   = 16'($urandom);
            x.pc  = 12'($urandom);
            x.idx = 4'($urandom);
            x.incr = ($urandom_range(0, 7) == 0);
            x.jmp = ($urandom_range(0, 3) == 0);
            x.bz  = ($urandom_range(0, 3) == 0);
            x.ld  = 1'($urandom);
            x.st  = 1'($urandom);
            x.wr  = 1'($urandom);
            drive(x);
        end
        for (int i = 0; i < 20; i++) idle();
        @(negedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
